// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state encoding, defaults and PC helper for the sequencer
package cpu_seq_pkg;

  localparam int STATE_W = 3;
  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;
  localparam int DEFAULT_MEM_WAIT_MAX = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } seqState_t;

  // Branch target is taken verbatim; sequential increment wraps at 16 bits.
  function automatic logic [15:0] nextPc(input logic [15:0] pc, input logic branch,
                                         input logic [15:0] target);
    return branch ? target : pc + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control/status bundle between the sequencer and its surroundings
interface cpu_seq_if;
  import cpu_seq_pkg::*;

  logic               start_i;
  logic [15:0]        start_address_i;
  logic [3:0]         opcode_i;
  logic               read_mem_i;
  logic               write_mem_i;
  logic               write_reg_i;
  logic               branch_i;
  logic [15:0]        branchloc_i;
  logic               mem_ready_i;

  logic [15:0]        pc_o;
  logic               ir_latch_o;
  logic               reg_we_o;
  logic               mem_rd_o;
  logic               mem_wr_o;
  logic [STATE_W-1:0] state_o;
  logic               busy_o;
  logic               halted_o;
  logic               fault_o;
  logic [15:0]        instr_count_o;

  modport master (
    output start_i, start_address_i, opcode_i, read_mem_i, write_mem_i, write_reg_i,
           branch_i, branchloc_i, mem_ready_i,
    input  pc_o, ir_latch_o, reg_we_o, mem_rd_o, mem_wr_o, state_o, busy_o, halted_o,
           fault_o, instr_count_o
  );

  modport slave (
    input  start_i, start_address_i, opcode_i, read_mem_i, write_mem_i, write_reg_i,
           branch_i, branchloc_i, mem_ready_i,
    output pc_o, ir_latch_o, reg_we_o, mem_rd_o, mem_wr_o, state_o, busy_o, halted_o,
           fault_o, instr_count_o
  );

endinterface

// File: rtl/cpu_sequencer_wait_timer.sv
// rtl/cpu_sequencer_wait_timer.sv - counts memory wait cycles and flags the last allowed one
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int LIMIT = DEFAULT_MEM_WAIT_MAX
) (
  input  logic clk,
  input  logic reset_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset_i || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // High during the LIMIT-th consecutive cycle spent waiting.
  assign expired = (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/writeback sequencer with wait timeout
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE  = DEFAULT_HALT_OPCODE,
  parameter int         MEM_WAIT_MAX = DEFAULT_MEM_WAIT_MAX
) (
  input  logic      clk,
  input  logic      reset_i,
  cpu_seq_if.slave  bus
);

  seqState_t   state;
  logic [15:0] pc;
  logic [15:0] instrCount;
  logic        irLatch;
  logic        regWe;
  logic        memRd;
  logic        memWr;
  logic        waitExpired;

  seq_wait_timer #(.LIMIT(MEM_WAIT_MAX)) waitTimer (
    .clk     (clk),
    .reset_i (reset_i),
    .clear   (state == S_EXEC),
    .enable  ((state == S_MEM) && !bus.mem_ready_i),
    .expired (waitExpired)
  );

  // Strobes are registered on entry to the state that owns them, so they
  // never follow mem_ready_i combinationally.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= S_IDLE;
      pc         <= '0;
      instrCount <= '0;
      irLatch    <= 1'b0;
      regWe      <= 1'b0;
      memRd      <= 1'b0;
      memWr      <= 1'b0;
    end else begin
      irLatch <= 1'b0;
      regWe   <= 1'b0;
      memRd   <= 1'b0;
      memWr   <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (bus.start_i) begin
            pc      <= bus.start_address_i;
            state   <= S_FETCH;
            irLatch <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: state <= (bus.opcode_i == HALT_OPCODE) ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (bus.read_mem_i || bus.write_mem_i) begin
            state <= S_MEM;
            memRd <= bus.read_mem_i & ~bus.write_mem_i;
            memWr <= bus.write_mem_i;
          end else begin
            state <= S_WB;
            regWe <= bus.write_reg_i;
          end
        end
        S_MEM: begin
          if (bus.mem_ready_i) begin
            state <= S_WB;
            regWe <= bus.write_reg_i;
          end else if (waitExpired) begin
            state <= S_FAULT;
          end else begin
            memRd <= bus.read_mem_i & ~bus.write_mem_i;
            memWr <= bus.write_mem_i;
          end
        end
        S_WB: begin
          pc      <= nextPc(pc, bus.branch_i, bus.branchloc_i);
          state   <= S_FETCH;
          irLatch <= 1'b1;
          if (instrCount != 16'hFFFF) begin
            instrCount <= instrCount + 16'd1;
          end
        end
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

  assign bus.pc_o          = pc;
  assign bus.ir_latch_o    = irLatch;
  assign bus.reg_we_o      = regWe;
  assign bus.mem_rd_o      = memRd;
  assign bus.mem_wr_o      = memWr;
  assign bus.state_o       = state;
  assign bus.busy_o        = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                             (state == S_MEM) || (state == S_WB);
  assign bus.halted_o      = (state == S_HALT);
  assign bus.fault_o       = (state == S_FAULT);
  assign bus.instr_count_o = instrCount;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized instruction-level bench with per-cycle trace comparison
module tb_cpu_sequencer;

  localparam int MAXW = 8;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] pc;
    logic [15:0] cnt;
    logic        ir;
    logic        we;
    logic        rd;
    logic        wr;
    logic        busy;
    logic        halted;
    logic        fault;
    logic        rdy;
  } rec_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int testsRun = 0;
  int testsFailed = 0;
  rec_t expRec;
  rec_t actRec;
  bit expValid = 1'b0;
  logic [15:0] mPc = '0;
  logic [15:0] mCount = '0;

  cpu_seq_if bus ();

  cpu_sequencer #(.HALT_OPCODE(4'hF), .MEM_WAIT_MAX(MAXW)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input int st, input logic [15:0] pc, input logic [15:0] cnt);
    rec_t r;
    r = '0;
    r.st = 3'(st);
    r.pc = pc;
    r.cnt = cnt;
    r.busy = (st >= 1 && st <= 5);
    r.halted = (st == 6);
    r.fault = (st == 7);
    return r;
  endfunction

  always @(negedge clk) begin
    if (expValid) begin
      actRec = '0;
      actRec.st = bus.state_o;
      actRec.pc = bus.pc_o;
      actRec.cnt = bus.instr_count_o;
      actRec.ir = bus.ir_latch_o;
      actRec.we = bus.reg_we_o;
      actRec.rd = bus.mem_rd_o;
      actRec.wr = bus.mem_wr_o;
      actRec.busy = bus.busy_o;
      actRec.halted = bus.halted_o;
      actRec.fault = bus.fault_o;
      actRec.rdy = expRec.rdy;
      testsRun++;
      if (actRec !== expRec) begin
        testsFailed++;
        $display("FAIL cycle_check t=%0t got st=%0d pc=%h cnt=%h ir=%b we=%b rd=%b wr=%b busy=%b halt=%b fault=%b required st=%0d pc=%h cnt=%h ir=%b we=%b rd=%b wr=%b busy=%b halt=%b fault=%b",
                 $time, actRec.st, actRec.pc, actRec.cnt, actRec.ir, actRec.we, actRec.rd, actRec.wr,
                 actRec.busy, actRec.halted, actRec.fault, expRec.st, expRec.pc, expRec.cnt,
                 expRec.ir, expRec.we, expRec.rd, expRec.wr, expRec.busy, expRec.halted, expRec.fault);
      end
    end
  end

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic stepTo(input rec_t e);
    @(posedge clk);
    #1;
    expRec = e;
    expValid = 1'b1;
  endtask

  task automatic noise();
    bus.start_i = 1'($urandom_range(0, 1));
    bus.start_address_i = 16'($urandom);
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    noise();
    bus.mem_ready_i = 1'b1;
    mPc = '0;
    mCount = '0;
    stepTo(mk(0, 16'h0, 16'h0));
    reset_i = 1'b0;
    bus.start_i = 1'b0;
    stepTo(mk(0, 16'h0, 16'h0));
  endtask

  task automatic startAt(input logic [15:0] addr);
    rec_t r;
    bus.start_i = 1'b1;
    bus.start_address_i = addr;
    mPc = addr;
    r = mk(1, addr, mCount);
    r.ir = 1'b1;
    stepTo(r);
    bus.start_i = 1'b0;
  endtask

  // Expects FETCH to be visible; builds the whole instruction's expected
  // trace from the rules, then plays it one clock per entry.
  task automatic runInstr(input logic [3:0] opc, input logic rd, input logic wr,
                          input logic wreg, input logic br, input logic [15:0] loc,
                          input int waits, input int resetAtMem,
                          output int latency, output int wrHigh, output int memCycles);
    rec_t q[$];
    rec_t r;
    rec_t prev;
    bus.opcode_i = opc;
    bus.read_mem_i = rd;
    bus.write_mem_i = wr;
    bus.write_reg_i = wreg;
    bus.branch_i = br;
    bus.branchloc_i = loc;
    latency = 0;
    wrHigh = 0;
    memCycles = 0;
    prev = mk(1, mPc, mCount);
    q.push_back(mk(2, mPc, mCount));
    if (opc == 4'hF) begin
      q.push_back(mk(6, mPc, mCount));
    end else begin
      q.push_back(mk(3, mPc, mCount));
      if (rd || wr) begin
        for (int k = 1; k <= MAXW; k++) begin
          r = mk(4, mPc, mCount);
          r.rd = rd && !wr;
          r.wr = wr;
          r.rdy = (k > waits);
          q.push_back(r);
          if (r.rdy) break;
        end
        if (!q[$].rdy) q.push_back(mk(7, mPc, mCount));
      end
      if (q[$].st != 3'd7) begin
        r = mk(5, mPc, mCount);
        r.we = wreg;
        q.push_back(r);
        mPc = br ? loc : mPc + 16'd1;
        if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
        r = mk(1, mPc, mCount);
        r.ir = 1'b1;
        q.push_back(r);
      end
    end
    foreach (q[i]) begin
      if (prev.st == 3'd4) begin
        memCycles++;
        bus.mem_ready_i = prev.rdy;
        if (memCycles == resetAtMem) begin
          doReset();
          return;
        end
      end else begin
        bus.mem_ready_i = 1'($urandom_range(0, 1));
      end
      noise();
      stepTo(q[i]);
      latency++;
      if (q[i].wr) wrHigh++;
      prev = q[i];
    end
    bus.start_i = 1'b0;
  endtask

  initial begin
    int lat;
    int wh;
    int mc;
    logic [3:0] opc;
    logic rd, wr, wreg, br;
    bus.start_i = 1'b0;
    bus.start_address_i = '0;
    bus.opcode_i = '0;
    bus.read_mem_i = 1'b0;
    bus.write_mem_i = 1'b0;
    bus.write_reg_i = 1'b0;
    bus.branch_i = 1'b0;
    bus.branchloc_i = '0;
    bus.mem_ready_i = 1'b0;

    doReset();
    checkEq("reset_pc", 32'(bus.pc_o), 32'h0);
    checkEq("reset_count", 32'(bus.instr_count_o), 32'h0);
    checkEq("reset_state", 32'(bus.state_o), 32'h0);

    startAt(16'h0010);
    runInstr(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 0, 0, lat, wh, mc);
    checkEq("alu_latency", 32'(lat), 32'd4);
    checkEq("alu_pc", 32'(bus.pc_o), 32'h0011);
    checkEq("alu_count", 32'(bus.instr_count_o), 32'd1);

    runInstr(4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 3, 0, lat, wh, mc);
    checkEq("store_latency", 32'(lat), 32'd8);
    checkEq("store_wr_cycles", 32'(wh), 32'd4);
    checkEq("store_pc", 32'(bus.pc_o), 32'h0012);

    runInstr(4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 0, 0, lat, wh, mc);
    checkEq("branch_ffff", 32'(bus.pc_o), 32'hFFFF);
    runInstr(4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 0, 0, lat, wh, mc);
    checkEq("pc_wrap", 32'(bus.pc_o), 32'h0000);
    runInstr(4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0042, 0, 0, lat, wh, mc);
    checkEq("load_latency", 32'(lat), 32'd5);
    checkEq("branch_pc", 32'(bus.pc_o), 32'h0042);

    runInstr(4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 0, 0, lat, wh, mc);
    checkEq("halt_pc", 32'(bus.pc_o), 32'h0042);
    checkEq("halt_flag", 32'(bus.halted_o), 32'h1);
    bus.start_i = 1'b0;
    stepTo(mk(6, mPc, mCount));
    stepTo(mk(6, mPc, mCount));
    startAt(16'h0020);
    checkEq("restart_pc", 32'(bus.pc_o), 32'h0020);
    checkEq("restart_count", 32'(bus.instr_count_o), 32'd5);

    for (int n = 0; n < 60; n++) begin
      opc = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wreg = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      runInstr(opc, rd, wr, wreg, br, 16'($urandom), $urandom_range(0, 5), 0, lat, wh, mc);
      if (opc == 4'hF) begin
        bus.start_i = 1'b0;
        for (int h = 0; h < int'($urandom_range(0, 3)); h++) stepTo(mk(6, mPc, mCount));
        startAt(16'($urandom));
      end
    end

    runInstr(4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 50, 2, lat, wh, mc);
    checkEq("abort_state", 32'(bus.state_o), 32'h0);
    checkEq("abort_memwr", 32'(bus.mem_wr_o), 32'h0);
    checkEq("abort_pc", 32'(bus.pc_o), 32'h0);
    checkEq("abort_count", 32'(bus.instr_count_o), 32'h0);

    startAt(16'h0100);
    runInstr(4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1000, 0, lat, wh, mc);
    checkEq("fault_mem_cycles", 32'(mc), 32'd8);
    checkEq("fault_flag", 32'(bus.fault_o), 32'h1);
    for (int s = 0; s < 3; s++) begin
      bus.start_i = 1'b1;
      bus.start_address_i = 16'($urandom);
      bus.mem_ready_i = 1'($urandom_range(0, 1));
      stepTo(mk(7, 16'h0100, mCount));
    end
    doReset();
    checkEq("post_fault_state", 32'(bus.state_o), 32'h0);

    @(posedge clk);
    expValid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
